// File: rtl/rshift_rne_sat.sv
// Requantizer: arithmetic right shift, round-half-to-even, saturate to OUT_W.
// Optional saturation flag output is enabled by defining RSHIFT_SAT_FLAG_EN.

module rshift_red_or #(
  parameter int W = 8
) (
  input  logic [W-1:0] vec_i,
  output logic         any_o
);
  assign any_o = |vec_i;
endmodule

module rshift_rne_sat #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 8,
  parameter int SH_W  = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rshift_in_valid_i,
  output logic                    rshift_in_ready_o,
  input  logic [IN_W-1:0]         rshift_data_i1,
  input  logic [SH_W-1:0]         rshift_sh_i2,
  output logic                    rshift_out_valid_o,
  input  logic                    rshift_out_ready_i,
  output logic [OUT_W-1:0]        rshift_data_o
`ifdef RSHIFT_SAT_FLAG_EN
  ,output logic                   rshift_sat_o
`endif
);
  localparam int SHE_W = $clog2(IN_W + 1);
  localparam logic signed [IN_W:0] SMAX = {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W:0] SMIN = {{(IN_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

  logic                    s1_valid_q, s2_valid_q, s1_adv;
  logic signed [IN_W:0]    q_d, q_q;
  logic                    guard_d, guard_q, sticky_d, sticky_q;
  logic [OUT_W-1:0]        data_d, data_q;
  logic [SHE_W-1:0]        she;
  logic signed [IN_W:0]    xext, r;
  logic [IN_W-1:0]         mask;
  logic                    inc, hi, lo;

  assign s1_adv             = !s2_valid_q || rshift_out_ready_i;
  assign rshift_in_ready_o  = !s1_valid_q || s1_adv;
  assign rshift_out_valid_o = s2_valid_q;
  assign rshift_data_o      = data_q;

  // S1: clamp the shift, floor-shift, and extract guard plus a masked sticky vector
  always_comb begin
    xext    = {rshift_data_i1[IN_W-1], rshift_data_i1};
    she     = (int'(rshift_sh_i2) >= IN_W) ? SHE_W'(IN_W) : SHE_W'(rshift_sh_i2);
    q_d     = xext >>> she;
    guard_d = 1'b0;
    mask    = '0;
    for (int i = 0; i < IN_W; i++) begin
      if (i + 1 == int'(she)) guard_d = xext[i];
      mask[i] = (i + 2 <= int'(she));
    end
  end

  rshift_red_or #(.W(IN_W)) u_sticky (
    .vec_i (rshift_data_i1 & mask),
    .any_o (sticky_d)
  );

  // S2: RNE increment then clamp
  always_comb begin
    inc    = guard_q & (sticky_q | q_q[0]);
    r      = q_q + (IN_W+1)'(inc);
    hi     = r > SMAX;
    lo     = r < SMIN;
    data_d = hi ? SMAX[OUT_W-1:0] : (lo ? SMIN[OUT_W-1:0] : r[OUT_W-1:0]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      q_q        <= '0;
      guard_q    <= 1'b0;
      sticky_q   <= 1'b0;
      data_q     <= '0;
    end else begin
      if (rshift_in_ready_o) begin
        s1_valid_q <= rshift_in_valid_i;
        if (rshift_in_valid_i) begin
          q_q      <= q_d;
          guard_q  <= guard_d;
          sticky_q <= sticky_d;
        end
      end
      if (s1_adv) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) data_q <= data_d;
      end
    end
  end

`ifdef RSHIFT_SAT_FLAG_EN
  logic sat_q;
  assign rshift_sat_o = sat_q;
  always_ff @(posedge clk) begin
    if (!rst_n)                     sat_q <= 1'b0;
    else if (s1_adv && s1_valid_q)  sat_q <= hi | lo;
  end
`endif

endmodule

// File: doc/rshift_rne_sat.md
Name: rshift_rne_sat

Overview:
- Pipelined requantization stage in the non-linear-ops datapath.
- Arithmetic right-shifts a wide signed accumulator by a per-sample amount, rounds round-half-to-even, then saturates to a narrow signed output.
- The sticky bit (OR of all bits below the guard bit) is produced by an instance of the existing reduction-OR block.
- Sits between accumulator/activation outputs and narrow-width consumers; valid/ready streaming on both sides.

Parameters:
- IN_W, 32, signed input width (>= 4)
- OUT_W, 8, signed output width (2 <= OUT_W <= IN_W)
- SH_W, 6, shift-amount width (2^SH_W >= IN_W)

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  synchronous active-low reset
- rshift_in_valid_i  input  1  input sample valid
- rshift_in_ready_o  output  1  stage can accept input
- rshift_data_i1  input  IN_W  signed input value x
- rshift_sh_i2  input  SH_W  unsigned shift amount sh
- rshift_out_valid_o  output  1  output sample valid
- rshift_out_ready_i  input  1  downstream accepts output
- rshift_data_o  output  OUT_W  signed rounded, saturated result

Behaviour:
- Function: rshift_data_o = sat_OUT_W(RNE(x / 2^sh)), where RNE rounds ties to even.
- Clock and reset: one clock, `clk`. Reset is synchronous and active-low on `rst_n`; it is sampled only on the rising edge of `clk`.
- Reset values: both stage-valid registers are 0, rshift_out_valid_o = 0, rshift_data_o = 0. rshift_in_ready_o is 1 in the first cycle after reset release.
- Reset mid-operation: all in-flight samples are discarded and no partial output is emitted.
- Transfer rule: a transfer occurs on a cycle where valid and ready are both 1 at the rising edge.
- Handshake rules:
  - rshift_out_valid_o and rshift_data_o hold stable while out_valid=1 and out_ready=0.
  - out_valid never depends combinationally on out_ready.
- Pipeline: two register stages S1 and S2. Latency is exactly 2 cycles from input transfer to out_valid, with no stall.
- Throughput and stall: 1 sample per cycle.
  - Each stage loads when it is empty or its contents advance in the same cycle.
  - rshift_in_ready_o = !s1_valid | s1_advance, where s1_advance = !s2_valid | rshift_out_ready_i.
  - A full pipeline with out_ready=0 holds both samples and drops nothing.
- S1 (shift and flags), computed from x and sh and registered:
  - Effective shift: she = min(sh, IN_W).
  - q = x >>> she (floor, sign-extended, carried at IN_W+1 bits).
  - guard = x[she-1] for 1 <= she < IN_W; guard = sign bit for she = IN_W; guard = 0 for she = 0.
  - sticky = OR of x[she-2:0], computed with the reduction-OR instance on a masked vector. sticky = 0 when she <= 1.
- S2 (round and saturate):
  - inc = guard & (sticky | q[0]); r = q + inc at IN_W+1 bits.
  - If r > 2^(OUT_W-1)-1, output 2^(OUT_W-1)-1. If r < -2^(OUT_W-1), output -2^(OUT_W-1). Otherwise output r truncated to OUT_W bits.
- Boundary conditions:
  - sh = 0 passes x through saturation only.
  - sh >= IN_W always yields 0 for all x, including -2^(IN_W-1), where the -0.5 tie rounds to the even value 0.
  - Simultaneous input accept and output drain in the same cycle is legal and must not insert bubbles.

Optional Feature:
- Macro: RSHIFT_SAT_FLAG_EN.
- When defined:
  - Adds port rshift_sat_o (output, 1 bit), registered alongside rshift_data_o with the same valid/stall semantics.
  - The flag is 1 when the S2 clamp engaged; reset value 0.
- When undefined: the port is absent and no saturation-detect flag is kept.
- Data path behaviour is identical in both cases.

Test Plan:
- Rounding, all cases with out_ready held 1, default parameters. Required output exactly 2 cycles after each input transfer:
  - x=10, sh=2 -> 2
  - x=14, sh=2 -> 4
  - x=11, sh=2 -> 3
  - x=-10, sh=2 -> -2
  - x=-11, sh=2 -> -3
- Saturation:
  - x=1000, sh=0 -> 127
  - x=-1000, sh=0 -> -128
  - x=-32768, sh=8 -> -128
  - x=32767, sh=8 -> 127 (rshift_sat_o=1 when enabled)
- Shift limits:
  - x=-2147483648, sh=32 -> 0
  - x=-1, sh=63 -> 0
  - x=5, sh=0 -> 5 with rshift_sat_o=0
- Backpressure: stream 5 samples back-to-back, hold out_ready=0 for 4 cycles, then release.
  - in_ready falls after exactly 2 samples are held.
  - Output data stays stable during the stall.
  - All 5 results appear in order with no loss or duplication.
- Full throughput: random x/sh stream with valid and out_ready held 1 for 1000 cycles. A reference model matches every output, and one output appears per cycle.
- Reset mid-stream: assert rst_n=0 for 1 cycle with both stages full.
  - Next cycle out_valid=0, rshift_data_o=0.
  - No stale sample is emitted after reset release.
